// File: rtl/rv32_pkg.sv
// Shared RV32I pipeline types and constants used by the instruction prefetch path.
package rv32_pkg;

    localparam int unsigned XLEN    = 32;
    localparam int unsigned INSTR_W = 32;

    localparam logic [XLEN-1:0] PC_STEP = 32'd4;

    typedef enum logic {
        PF_FETCH = 1'b0,
        PF_FLUSH = 1'b1
    } pf_state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [XLEN-1:0]    pc;
    } pf_entry_t;

endpackage

// File: rtl/pf_fifo.sv
// Synchronous FIFO of prefetched {instr, pc} entries with single-cycle flush.
module pf_fifo
    import rv32_pkg::*;
#(
    parameter  int unsigned DEPTH = 4,
    localparam int unsigned AW    = $clog2(DEPTH),
    localparam int unsigned CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  pf_entry_t     din,
    output pf_entry_t     head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    pf_entry_t     mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count = wr_ptr - rd_ptr;
    assign head  = mem[rd_ptr[AW-1:0]];

    // A push into a full FIFO is honoured only when the head leaves the same cycle
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (do_pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/instr_prefetch_buffer.sv
// In-order instruction prefetcher: credit-limited memory reads feeding a PC-tagged
// FIFO, with execute-stage redirect that flushes the queue and drops in-flight data.
module instr_prefetch_buffer
    import rv32_pkg::*;
#(
    parameter int unsigned     DEPTH           = 4,
    parameter int unsigned     MAX_OUTSTANDING = 2,
    parameter logic [XLEN-1:0] RESET_PC        = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               PCSrcE,
    input  logic [XLEN-1:0]    PCTargetE,
    output logic               imem_req,
    output logic [XLEN-1:0]    imem_addr,
    input  logic               imem_gnt,
    input  logic               imem_rvalid,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [XLEN-1:0]    out_pc,
    output logic [XLEN-1:0]    out_pcplus4
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned OW = $clog2(DEPTH + 1);

    pf_state_e       state;
    pf_state_e       state_nxt;
    logic [OW-1:0]   discard_cnt;
    logic [OW-1:0]   discard_nxt;
    logic [OW-1:0]   outstanding;
    logic [XLEN-1:0] fetch_pc;
    logic [XLEN-1:0] resp_pc;
    logic [XLEN-1:0] target_pc;

    logic            handshake;
    logic            drop;
    logic            fifo_push;
    logic            fifo_pop;
    logic            credit_ok;
    pf_entry_t       fifo_din;
    pf_entry_t       fifo_head;
    logic [CW-1:0]   fifo_count;
    logic            fifo_full;
    logic            fifo_empty;

    assign target_pc = PCTargetE & ~32'h0000_0003;

    // Credits cover every in-flight response, so a returning word always has a FIFO slot
    assign credit_ok = ~fifo_full
                     && (outstanding < OW'(MAX_OUTSTANDING))
                     && ((32'(fifo_count) + 32'(outstanding)) < DEPTH);

    assign imem_req  = ~rst & ~PCSrcE & credit_ok;
    assign imem_addr = fetch_pc;
    assign handshake = imem_req & imem_gnt;

    assign drop      = imem_rvalid & (PCSrcE | (state == PF_FLUSH));
    assign fifo_push = imem_rvalid & ~drop;
    assign fifo_pop  = out_valid & out_ready & ~PCSrcE;
    assign fifo_din  = '{instr: imem_rdata, pc: resp_pc};

    pf_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (PCSrcE),
        .din   (fifo_din),
        .head  (fifo_head),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign out_valid   = ~fifo_empty;
    assign out_instr   = fifo_empty ? '0 : fifo_head.instr;
    assign out_pc      = fifo_empty ? '0 : fifo_head.pc;
    assign out_pcplus4 = fifo_empty ? '0 : fifo_head.pc + PC_STEP;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= PF_FETCH;
            discard_cnt <= '0;
        end else begin
            state       <= state_nxt;
            discard_cnt <= discard_nxt;
        end
    end

    // Redirect reloads the discard count from what is still in flight after this cycle
    always_comb begin
        state_nxt   = state;
        discard_nxt = discard_cnt;
        if (PCSrcE) begin
            discard_nxt = outstanding - OW'(imem_rvalid);
            state_nxt   = (discard_nxt != '0) ? PF_FLUSH : PF_FETCH;
        end else if (state == PF_FLUSH && imem_rvalid) begin
            discard_nxt = discard_cnt - OW'(1);
            if (discard_nxt == '0) state_nxt = PF_FETCH;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc    <= RESET_PC;
            resp_pc     <= RESET_PC;
            outstanding <= '0;
        end else begin
            outstanding <= outstanding + OW'(handshake) - OW'(imem_rvalid);
            if (PCSrcE) begin
                fetch_pc <= target_pc;
                resp_pc  <= target_pc;
            end else begin
                if (handshake) fetch_pc <= fetch_pc + PC_STEP;
                if (fifo_push) resp_pc  <= resp_pc + PC_STEP;
            end
        end
    end

endmodule

// File: tb/tb_instr_prefetch_buffer.sv
// Scoreboard bench for instr_prefetch_buffer with an in-order variable-latency memory model.
module tb_instr_prefetch_buffer;
    import rv32_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        PCSrcE = 1'b0;
    logic [31:0] PCTargetE = '0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b1;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [31:0] out_pcplus4;

    always #5 clk = ~clk;

    instr_prefetch_buffer #(.DEPTH(4), .MAX_OUTSTANDING(2), .RESET_PC(32'h0)) dut (
        .clk         (clk),
        .rst         (rst),
        .PCSrcE      (PCSrcE),
        .PCTargetE   (PCTargetE),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .out_pcplus4 (out_pcplus4)
    );

    typedef struct {
        logic [31:0] addr;
        int          ret;
    } mreq_t;

    mreq_t       mq[$];
    logic [31:0] exp_q[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          lat   = 1;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a == 32'h0) ? 32'h0050_0093 : (a ^ 32'h1357_0013);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_run(input logic [31:0] base, input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(base + 32'(4 * i));
    endtask

    task automatic wait_drain(input string name, input int bound);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < bound) begin
            @(posedge clk);
            n++;
        end
        #1;
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    // Memory: grant sampled at edge t, rvalid presented for edge t+lat, strictly in order
    initial forever begin
        @(negedge clk);
        imem_rvalid = 1'b0;
        if (rst) begin
            mq.delete();
        end else begin
            if (imem_req && imem_gnt) mq.push_back('{addr: imem_addr, ret: cyc + 1 + lat});
            if (mq.size() > 0 && mq[0].ret <= cyc + 1) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_word(mq[0].addr);
                void'(mq.pop_front());
            end
            check("outstanding_le_2", 32'(mq.size() <= 2), 32'd1);
        end
    end

    // Monitor: every accepted instruction must be the next expected one
    initial forever begin
        @(negedge clk);
        if (!rst && !PCSrcE && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL spurious_output: got pc %h want none", out_pc);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("out_pc", out_pc, e);
                check("out_pcplus4", out_pcplus4, e + 32'd4);
                check("out_instr", out_instr, mem_word(e));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset values, first fetch, minimum latency and streaming
        rst = 1'b1; lat = 1; out_ready = 1'b1;
        repeat (2) step();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_out_pc", out_pc, 32'h0);
        check("rst_out_pcplus4", out_pcplus4, 32'h0);
        check("rst_out_instr", out_instr, 32'h0);
        expect_run(32'h0, 12);
        rst = 1'b0;
        @(negedge clk);
        check("first_req", 32'(imem_req), 32'd1);
        check("first_addr", imem_addr, 32'h0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        check("lat_out_valid", 32'(out_valid), 32'd1);
        check("lat_out_pc", out_pc, 32'h0);
        check("lat_out_pcplus4", out_pcplus4, 32'h4);
        check("lat_out_instr", out_instr, 32'h0050_0093);
        wait_drain("stream_drain", 40);
        out_ready = 1'b0;

        // Backpressure fills the FIFO, then resumes without a PC gap
        rst = 1'b1;
        repeat (2) step();
        rst = 1'b0;
        repeat (8) step();
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("full_out_valid", 32'(out_valid), 32'd1);
            check("full_no_req", 32'(imem_req), 32'd0);
            check("full_head_pc", out_pc, 32'h0);
        end
        step();
        out_ready = 1'b1;
        expect_run(32'h0, 8);
        @(negedge clk);
        check("resume_wait_req", 32'(imem_req), 32'd0);
        @(negedge clk);
        check("resume_req", 32'(imem_req), 32'd1);
        check("resume_addr", imem_addr, 32'h10);
        wait_drain("resume_drain", 40);
        out_ready = 1'b0;
        repeat (8) step();
        check("refull_valid", 32'(out_valid), 32'd1);
        check("refull_no_req", 32'(imem_req), 32'd0);
        check("refull_head_pc", out_pc, 32'h20);

        // Asynchronous reset with a full FIFO, then restart at the reset PC
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check("async_out_valid", 32'(out_valid), 32'd0);
        check("async_imem_req", 32'(imem_req), 32'd0);
        check("async_out_pc", out_pc, 32'h0);
        repeat (2) step();
        expect_run(32'h0, 4);
        out_ready = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        check("restart_req", 32'(imem_req), 32'd1);
        check("restart_addr", imem_addr, 32'h0);
        wait_drain("restart_drain", 40);
        out_ready = 1'b0;

        // Redirect with two outstanding requests and 3-cycle memory latency
        rst = 1'b1; lat = 3; out_ready = 1'b1;
        repeat (2) step();
        expect_run(32'h100, 4);
        rst = 1'b0;
        step();
        step();
        PCSrcE = 1'b1; PCTargetE = 32'h100;
        step();
        PCSrcE = 1'b0;
        @(negedge clk);
        check("redir_addr", imem_addr, 32'h100);
        check("redir_no_req", 32'(imem_req), 32'd0);
        check("redir_out_valid", 32'(out_valid), 32'd0);
        wait_drain("redir_drain", 60);
        out_ready = 1'b0;

        // Redirect to an unaligned target coinciding with a returning response
        rst = 1'b1; lat = 2; out_ready = 1'b1;
        repeat (2) step();
        expect_run(32'h100, 4);
        rst = 1'b0;
        step();
        step();
        PCSrcE = 1'b1; PCTargetE = 32'h103;
        step();
        PCSrcE = 1'b0;
        @(negedge clk);
        check("coinc_addr", imem_addr, 32'h100);
        check("coinc_req", 32'(imem_req), 32'd1);
        wait_drain("coinc_drain", 60);
        out_ready = 1'b0;
        repeat (2) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instr_prefetch_buffer.md
Name: instr_prefetch_buffer

Overview:
Instruction prefetch queue between the instruction memory port and the fetch stage of the 5-stage RV32I pipeline. It issues in-order word reads to a variable-latency instruction memory and buffers the returned instructions with their PC and PC+4. It presents them to the fetch/decode boundary through a valid/ready handshake. A redirect from the execute stage (PCSrcE/PCTargetE) flushes the queue and discards in-flight responses.

Parameters:
DEPTH, 4, FIFO entries (power of 2, >=2)
MAX_OUTSTANDING, 2, max issued-but-unreturned memory requests (1..DEPTH)
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous, active-high reset
PCSrcE  in  1  redirect request from execute stage
PCTargetE  in  32  redirect target address
imem_req  out  1  read request valid
imem_addr  out  32  word-aligned read address
imem_gnt  in  1  request accepted this cycle (handshake = imem_req & imem_gnt)
imem_rvalid  in  1  read data valid; responses return in request order, >=1 cycle after grant
imem_rdata  in  32  instruction word
out_valid  out  1  buffered instruction available
out_ready  in  1  fetch stage accepts (low = stall)
out_instr  out  32  instruction at queue head
out_pc  out  32  PC of out_instr
out_pcplus4  out  32  out_pc + 4

Behaviour:
- Reset (async): fetch_pc=RESET_PC, resp_pc=RESET_PC, outstanding=0, discard_cnt=0, FIFO empty, state=FETCH. out_valid=0, imem_req=0, out_instr/out_pc/out_pcplus4=0.
- imem_addr = fetch_pc. fetch_pc[1:0] is always 00. A redirect target has bits [1:0] forced to 00.
- imem_req = !PCSrcE & (outstanding < MAX_OUTSTANDING) & (fifo_count + outstanding < DEPTH). This credit rule guarantees no response ever finds the FIFO full.
- On a handshake, fetch_pc += 4 and outstanding increments. fetch_pc wraps modulo 2^32.
- On imem_rvalid, outstanding decrements. Same-cycle issue and return give a net 0 change.
  - If discard_cnt>0, the response is dropped and discard_cnt decrements.
  - Otherwise {imem_rdata, resp_pc} is pushed, resp_pc += 4.
- Output: out_valid = FIFO non-empty. Head fields are driven combinationally from the FIFO; out_pcplus4 = out_pc+4.
- Pop occurs when out_valid & out_ready. Push and pop in the same cycle are both honoured, including at full and at empty (a push into an empty FIFO is visible the next cycle).
- Min latency: request grant at cycle t, rvalid at t+1, out_valid at t+2.
- Redirect (PCSrcE=1), highest priority:
  - imem_req=0 that cycle, the FIFO is cleared, and any pop that cycle is ignored (the downstream flushes too).
  - fetch_pc and resp_pc load {PCTargetE[31:2],2'b00}.
  - discard_cnt loads outstanding - imem_rvalid. A response arriving in the redirect cycle is dropped regardless.
  - outstanding updates normally.
  - State goes to FLUSH if the new discard_cnt>0, else FETCH.
- State machine:
  - FETCH: normal operation.
  - FLUSH: discard_cnt>0. New requests may still issue, since responses are in order and new data follows the discarded responses.
  - FLUSH -> FETCH when discard_cnt reaches 0 via a dropped rvalid.
  - A redirect while in FLUSH reloads discard_cnt by the same rule.
- Back-to-back redirects are legal; each one supersedes the previous.
- Reset mid-operation: all counters are lost. The instruction memory shares rst and must not return responses for pre-reset requests.

Decomposition:
- Shared package rv32_pkg:
  - XLEN=32 and INSTR_W=32 constants.
  - PC_STEP=4.
  - Prefetch state enum {PF_FETCH, PF_FLUSH}.
  - Prefetch entry struct {instr, pc}.
- One sub-module pf_fifo:
  - Synchronous FIFO with parameter DEPTH and width 64.
  - Ports: push, pop, flush, count, full, empty, head data.
  - Pointers are log2(DEPTH) bits plus a wrap bit.
  - Asynchronous active-high reset on rst.

Test Plan:
1. Reset, then release with memory granting always and a 1-cycle response latency returning word 0x00500093 at address 0 -> imem_req=1 with imem_addr=0 in the first cycle after release; out_valid=1 two cycles after the grant with out_pc=0, out_pcplus4=4, out_instr=0x00500093.
2. Streaming with out_ready=1 and always-grant -> out_pc sequence 0,4,8,12,... on consecutive cycles; outstanding never exceeds 2.
3. Backpressure with out_ready=0 -> the FIFO fills to 4 entries (pc 0..12); imem_req stays 0 while count+outstanding=4; raising out_ready resumes requests at 0x10 with no PC gap.
4. Redirect: PCSrcE=1, PCTargetE=0x100 with 2 outstanding and a 3-cycle memory latency -> both stale responses are dropped; the next out_valid has out_pc=0x100, out_pcplus4=0x104; no stale PC is ever output.
5. Redirect with PCTargetE=0x103 coinciding with imem_rvalid -> imem_addr=0x100 next cycle; the coincident response is dropped; discard_cnt = outstanding-1.
6. Reset asserted asynchronously mid-stream with a full FIFO -> out_valid=0 and imem_req=0 immediately; after release, fetch restarts at RESET_PC.
